button_debouncer: RTL and testbench
===================================

# button_debouncer

Front-end conditioning stage for a raw mechanical push-button input. Synchronises the asynchronous pin into the `clk` domain and filters contact bounce. Emits a clean level that feeds the rising-edge detector directly downstream, plus an optional one-cycle press pulse. One instance per board button.

## Interface
- `STABLE_CYCLES`, default 1_000_000: consecutive synchronised cycles at a new level required before `clean` changes (10 ms at 100 MHz). Legal range ≥ 2.
- `CNT_W`, default 20: counter width. Must satisfy 2^CNT_W > STABLE_CYCLES-1.
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low reset. Asserts immediately; deassertion is taken on a `clk` edge.
- `btn_raw`  input  1  raw button pin, asynchronous, may bounce.
- `clean`  output  1  debounced level, registered.
- `press`  output  1  one-cycle pulse on a debounced 0→1 transition, registered. Present only with `DEBOUNCE_PULSE_EN`; otherwise held 0.

## Operation
- Two-flop synchroniser: `sync1 <= btn_raw`, `sync2 <= sync1`. The FSM observes only `sync2`.
- Counter `cnt` is `CNT_W` bits, unsigned.
- FSM states:
  - STABLE_LO: `clean`=0, `cnt`=0. Moves to WAIT_HI when `sync2`=1.
  - WAIT_HI: `clean`=0.
    - If `sync2`=0, return to STABLE_LO and clear `cnt` (bounce rejected).
    - Else if `cnt`==STABLE_CYCLES-1, go to STABLE_HI and set `clean`=1.
    - Else increment `cnt`.
  - STABLE_HI: `clean`=1, `cnt`=0. Moves to WAIT_LO when `sync2`=0.
  - WAIT_LO: mirror of WAIT_HI with polarity inverted. On completion, go to STABLE_LO and set `clean`=0.
- `cnt` is cleared on every entry to a WAIT state. It never wraps, because it saturates by transition at STABLE_CYCLES-1.
- `clean` is driven from a register that changes on the same edge as the state change. It is not decoded combinationally from the state.
- Unreachable state encodings recover to STABLE_LO with `cnt`=0 and `clean`=0.

## Timing
- Reset values: `sync1`=0, `sync2`=0, state=STABLE_LO, `cnt`=0, `clean`=0, `press`=0.
- Latency for a bounce-free step captured by `sync1` at edge k:
  - `sync2` updates at edge k+1.
  - WAIT entered at edge k+2.
  - `clean` updates at edge k+2+STABLE_CYCLES, i.e. exactly STABLE_CYCLES+2 cycles after capture.
- Any reversal of `sync2` during WAIT restarts qualification. The full STABLE_CYCLES is required again after the next change.
- A glitch shorter than one `clk` period may or may not be captured. If captured, it is rejected whenever it is shorter than STABLE_CYCLES.
- Reset asserted mid-WAIT aborts qualification. All outputs return to reset values immediately; no `press` is emitted.
- Button held at 1 through reset deassertion: the block starts in STABLE_LO and qualifies normally. `clean` rises STABLE_CYCLES+2 cycles after the first post-reset capture of 1.

## Configuration
- `DEBOUNCE_PULSE_EN` defined:
  - `press` <= 1 on the same edge that `clean` goes 0→1, and 0 on every other edge. Width is exactly one cycle.
  - No pulse on a 1→0 transition.
- `DEBOUNCE_PULSE_EN` undefined: the `press` register is omitted and `press` is tied to 0. `clean` behaviour is identical in both builds.

## Test plan
All scenarios use STABLE_CYCLES=4, CNT_W=3.
- Reset: hold `reset`=0 with `btn_raw`=1 for 10 cycles. `clean`=0 and `press`=0 throughout.
- Clean press: after reset, step `btn_raw` 0→1 and hold. `clean` rises exactly 6 cycles after the capturing edge. With the macro, `press`=1 for exactly that one cycle.
- Bounce rejection: drive `btn_raw` pattern 1,1,0,1,1,1,0 (one value per cycle), then hold 1. `clean` stays 0 until 6 cycles after the final 0→1 capture.
- Release: from `clean`=1, step `btn_raw` to 0. `clean` falls 6 cycles later and `press` stays 0.
- Reset mid-WAIT: assert `reset` 2 cycles into WAIT_HI. Outputs drop immediately. After deassertion, a held-1 input qualifies with full latency.
- Macro off: repeat the clean-press scenario. `clean` timing is identical and `press`=0 always.

Source files
------------

// File: rtl/button_debouncer_if.sv
// rtl/button_debouncer_if.sv - signal bundle between a push-button pin and its debouncer
//
// Purpose: groups the raw pin and the conditioned outputs of one button.
// Signals:
//   btn_raw  raw button pin, asynchronous, may bounce
//   clean    debounced level
//   press    one-cycle pulse on a debounced 0->1 transition (0 when the pulse build is off)
// Modports:
//   master   drives the pin, observes the conditioned outputs (board / testbench side)
//   slave    the debouncer itself
interface button_debouncer_if;
   logic btn_raw;
   logic clean;
   logic press;

   modport master (output btn_raw, input clean, input press);
   modport slave  (input btn_raw, output clean, output press);
endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchroniser and bounce filter for one mechanical push-button
//
// Purpose: brings the asynchronous button pin into the clk domain through a
// two-flop synchroniser, then requires STABLE_CYCLES consecutive cycles at a
// new level before the registered clean output follows it.
// Parameters:
//   STABLE_CYCLES  qualification length in clk cycles (>= 2)
//   CNT_W          counter width, 2**CNT_W > STABLE_CYCLES-1
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    button_debouncer_if.slave: btn_raw in, clean / press out
// Build option:
//   DEBOUNCE_PULSE_EN  when defined, press pulses for one cycle on the same edge
//                      clean goes 0->1; when undefined press is tied to 0.
module button_debouncer #(
   parameter int STABLE_CYCLES = 1_000_000,
   parameter int CNT_W         = 20
) (
   input  logic                 clk,
   input  logic                 reset,
   button_debouncer_if.slave    bus
);

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             clean_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         state   <= STABLE_LO;
         cnt     <= '0;
         clean_q <= 1'b0;
      end else begin
         sync1 <= bus.btn_raw;
         sync2 <= sync1;

         case (state)
            STABLE_LO: begin
               clean_q <= 1'b0;
               cnt     <= '0;
               if (sync2) state <= WAIT_HI;
            end
            WAIT_HI: begin
               if (!sync2) begin
                  // bounce: give up and demand a full qualification next time
                  state <= STABLE_LO;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state   <= STABLE_HI;
                  clean_q <= 1'b1;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STABLE_HI: begin
               clean_q <= 1'b1;
               cnt     <= '0;
               if (!sync2) state <= WAIT_LO;
            end
            WAIT_LO: begin
               if (sync2) begin
                  state <= STABLE_HI;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state   <= STABLE_LO;
                  clean_q <= 1'b0;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state   <= STABLE_LO;
               cnt     <= '0;
               clean_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.clean = clean_q;

`ifdef DEBOUNCE_PULSE_EN
   logic press_q;

   // Fires on exactly the edge where WAIT_HI completes, i.e. the edge clean rises.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         press_q <= 1'b0;
      end else begin
         press_q <= (state == WAIT_HI) && sync2 && (cnt == CNT_LAST);
      end
   end

   assign bus.press = press_q;
`else
   assign bus.press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - self-checking bench for button_debouncer (STABLE_CYCLES=4, CNT_W=3)
module tb_button_debouncer;

   localparam int SC = 4;
`ifdef DEBOUNCE_PULSE_EN
   localparam bit PULSE_EN = 1'b1;
`else
   localparam bit PULSE_EN = 1'b0;
`endif

   logic clk;
   logic reset;
   button_debouncer_if bus ();

   button_debouncer #(.STABLE_CYCLES(SC), .CNT_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic raw;
      logic c;
      logic p;
   } vec_t;
   vec_t tbl[$];

   // Reference model: raw pin samples per rising edge. clean toggles on edge n
   // when the samples taken at edges n-2 .. n-2-SC (SC+1 consecutive synchronised
   // values) all differ from the current clean level.
   bit   hist[$];
   logic m_clean;
   logic m_press;

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0b expected=%0b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < SC + 4; i++) hist.push_back(1'b0);
      m_clean = 1'b0;
      m_press = 1'b0;
   endtask

   task automatic model_step(input logic raw);
      bit flip;
      hist.push_back(raw);
      if (hist.size() > 32) void'(hist.pop_front());
      flip = 1'b1;
      for (int j = 2; j <= SC + 2; j++)
         if (hist[hist.size() - 1 - j] == m_clean) flip = 1'b0;
      m_press = 1'b0;
      if (flip) begin
         m_clean = ~m_clean;
         m_press = PULSE_EN && m_clean;
      end
   endtask

   // Drive raw away from the edge, clock once, sample on the falling edge.
   task automatic cycle(input logic raw);
      bus.btn_raw = raw;
      @(posedge clk);
      model_step(raw);
      @(negedge clk);
   endtask

   task automatic add(input logic raw, input logic c, input logic p, input int n);
      vec_t v;
      v.raw = raw; v.c = c; v.p = p;
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   initial begin
      int lat;
      bus.btn_raw = 1'b1;
      reset = 1'b0;
      model_reset();

      // Reset held with the button pressed: outputs stay at 0.
      #1;
      chk("reset_clean_t0", bus.clean, 1'b0);
      chk("reset_press_t0", bus.press, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("reset_clean", bus.clean, 1'b0);
         chk("reset_press", bus.press, 1'b0);
      end
      reset = 1'b1;

      // Clean press, release, bounce rejection: expected values per edge.
      add(0, 0, 0, 3);
      add(1, 0, 0, 6);
      add(1, 1, 1, 1);
      add(1, 1, 0, 2);
      add(0, 1, 0, 6);
      add(0, 0, 0, 3);
      add(1, 0, 0, 2);
      add(0, 0, 0, 1);
      add(1, 0, 0, 3);
      add(0, 0, 0, 1);
      add(1, 0, 0, 6);
      add(1, 1, 1, 1);
      add(1, 1, 0, 1);
      foreach (tbl[i]) begin
         cycle(tbl[i].raw);
         chk($sformatf("tbl_clean[%0d]", i), bus.clean, tbl[i].c);
         chk($sformatf("tbl_press[%0d]", i), bus.press, PULSE_EN ? tbl[i].p : 1'b0);
      end

      // Reset in the middle of a release qualification drops clean at once.
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0);
         chk("wait_lo_clean_held", bus.clean, 1'b1);
      end
      reset = 1'b0;
      #1;
      chk("reset_wait_lo_clean", bus.clean, 1'b0);
      chk("reset_wait_lo_press", bus.press, 1'b0);
      reset = 1'b1;
      model_reset();

      // Reset two cycles into WAIT_HI, then full latency after release of reset.
      for (int i = 0; i < 4; i++) cycle(1'b1);
      reset = 1'b0;
      model_reset();
      #1;
      chk("reset_wait_hi_clean", bus.clean, 1'b0);
      chk("reset_wait_hi_press", bus.press, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("reset_hold_press", bus.press, 1'b0);
      end
      reset = 1'b1;
      lat = -1;
      for (int i = 0; i < 20 && lat < 0; i++) begin
         cycle(1'b1);
         if (bus.clean === 1'b1) begin
            lat = i;
            chk("post_reset_press", bus.press, PULSE_EN);
         end
      end
      checks++;
      if (lat != SC + 2) begin
         errors++;
         $display("FAIL post_reset_latency actual=%0d expected=%0d", lat, SC + 2);
      end

      // Randomised hold lengths against the reference model.
      for (int r = 0; r < 400; r++) begin
         logic v;
         int   len;
         v   = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 9);
         for (int k = 0; k < len; k++) begin
            cycle(v);
            chk("rand_clean", bus.clean, m_clean);
            chk("rand_press", bus.press, m_press);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
